// File: rtl/ela_row_feeder.sv
// ela_row_feeder: streams one ROM row per request to the ELA core and tracks frame completion
module ela_row_feeder #(
    parameter int DW   = 8,
    parameter int COLS = 16,
    parameter int ROWS = 5,
    parameter int AW   = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    output logic [AW-1:0] rom_addr_o,
    input  logic [DW-1:0] rom_data_i,
    output logic [DW-1:0] in_data_o,
    output logic          pix_vld_o,
    output logic [2:0]    row_idx_o,
    output logic          frame_done_o,
    output logic          overreq_o
);
    localparam int CW = $clog2(COLS + 1);
    typedef enum logic {IDLE, SEND} state_t;
    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [2:0]    row_q;
    // Row FSM: IDLE accepts a request and loads pixel 0, SEND loads the rest of the row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            rom_addr_o   <= '0;
            in_data_o    <= '0;
            pix_vld_o    <= 1'b0;
            row_idx_o    <= '0;
            frame_done_o <= 1'b0;
            overreq_o    <= 1'b0;
        end else begin
            overreq_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i && !frame_done_o) begin
                        in_data_o  <= rom_data_i;
                        pix_vld_o  <= 1'b1;
                        rom_addr_o <= rom_addr_o + AW'(1);
                        col_q      <= CW'(1);
                        row_idx_o  <= row_q;
                        row_q      <= row_q + 3'd1;
                        state_q    <= SEND;
                    end else begin
                        pix_vld_o <= 1'b0;
                        overreq_o <= req_i && frame_done_o;
                    end
                end
                SEND: begin
                    in_data_o  <= rom_data_i;
                    rom_addr_o <= rom_addr_o + AW'(1);
                    col_q      <= (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
                    state_q    <= (col_q == CW'(COLS - 1)) ? IDLE : SEND;
                    if (col_q == CW'(COLS - 1) && row_idx_o == 3'(ROWS - 1))
                        frame_done_o <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ela_row_feeder.sv
// tb_ela_row_feeder: scoreboard bench for ela_row_feeder with a ROM returning its own address
module tb_ela_row_feeder;
    localparam int DW = 8, COLS = 16, ROWS = 5, AW = 7;
    logic          clk = 1'b0, rst = 1'b0, req = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data, in_data;
    logic          pix_vld, frame_done, overreq;
    logic [2:0]    row_idx;
    int vectors = 0, errors = 0;
    typedef struct packed {logic [DW-1:0] d; logic [2:0] r;} exp_t;
    exp_t q[$];
    int   busy = 0, rows = 0, loaded = 0;
    logic exp_done = 1'b0, exp_over = 1'b0;

    ela_row_feeder #(.DW(DW), .COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req_i(req), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .in_data_o(in_data), .pix_vld_o(pix_vld), .row_idx_o(row_idx),
        .frame_done_o(frame_done), .overreq_o(overreq)
    );

    assign rom_data = DW'(rom_addr);
    always #5 clk = ~clk;

    task automatic check(string n, logic [31:0] a, logic [31:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference: a row is a block of COLS consecutive ROM words; requests only count when not busy
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            busy = 0; rows = 0; loaded = 0; exp_done = 1'b0; exp_over = 1'b0;
        end else begin
            exp_over = 1'b0;
            if (busy > 0) begin
                busy--;
                loaded++;
                if (busy == 0 && rows == ROWS) exp_done = 1'b1;
            end else if (req) begin
                if (rows < ROWS) begin
                    for (int k = 0; k < COLS; k++) q.push_back('{d: DW'(rows * COLS + k), r: 3'(rows)});
                    busy = COLS - 1;
                    loaded++;
                    rows++;
                end else exp_over = 1'b1;
            end
        end
    end

    // Monitor: every cycle the outputs must match the reference stream
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("pix_vld", 32'(pix_vld), 32'(q.size() != 0));
            if (q.size() != 0) begin
                e = q.pop_front();
                check("in_data", 32'(in_data), 32'(e.d));
                check("row_idx", 32'(row_idx), 32'(e.r));
            end else
                check("in_data_hold", 32'(in_data), (loaded == 0) ? 32'd0 : 32'(DW'(loaded - 1)));
            check("rom_addr", 32'(rom_addr), 32'(loaded));
            check("frame_done", 32'(frame_done), 32'(exp_done));
            check("overreq", 32'(overreq), 32'(exp_over));
        end
    end

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_data", 32'(in_data), 32'd0);
        check("rst_vld", 32'(pix_vld), 32'd0);
        check("rst_row", 32'(row_idx), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_over", 32'(overreq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        req = 1'b1;
        cyc(1);
        req = 1'b0;
    endtask

    initial begin
        // single row
        do_reset();
        pulse();
        cyc(20);
        check("t1_addr", 32'(rom_addr), 32'd16);
        // five spaced rows, then an over-request
        do_reset();
        for (int i = 0; i < ROWS; i++) begin
            pulse();
            cyc(39);
        end
        check("t2_done", 32'(frame_done), 32'd1);
        check("t2_addr", 32'(rom_addr), 32'd80);
        pulse();
        cyc(3);
        // continuous request: back-to-back rows then overreq every cycle
        do_reset();
        req = 1'b1;
        cyc(100);
        req = 1'b0;
        check("t3_data", 32'(in_data), 32'h4f);
        cyc(3);
        // request toggled during a row
        do_reset();
        pulse();
        cyc(20);
        pulse();
        cyc(2);
        for (int i = 3; i <= 8; i++) begin
            req = 1'($urandom_range(0, 1));
            cyc(1);
        end
        req = 1'b0;
        cyc(20);
        check("t4_addr", 32'(rom_addr), 32'd32);
        // reset in the middle of row 2
        do_reset();
        pulse();
        cyc(20);
        pulse();
        cyc(20);
        pulse();
        cyc(7);
        do_reset();
        pulse();
        cyc(20);
        check("t5_addr", 32'(rom_addr), 32'd16);
        // random request traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        req = 1'b0;
        cyc(20);
        check("drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
